// File: rtl/ecc_rom_reader_pkg.sv
// Shared widths, FSM encoding and in-flight tag type for the ECC ROM burst reader.
package ecc_rom_reader_pkg;

  localparam int unsigned ROM_AW     = 6;
  localparam int unsigned ROM_DW     = 16;
  localparam int unsigned FIFO_DEPTH = 4;
  localparam int unsigned LEN_W      = 5;
  localparam int unsigned FIFO_W     = ROM_DW + 1;
  localparam int unsigned PTR_W      = 2;
  localparam int unsigned CNT_W      = 3;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  // One in-flight ROM read: valid plus "this is the final word of the burst".
  typedef struct packed {
    logic vld;
    logic last;
  } tag_t;

endpackage

// File: rtl/ecc_rom_fifo.sv
// 4-entry synchronous FIFO holding ROM words with their end-of-burst flag.
module ecc_rom_fifo
  import ecc_rom_reader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              push_i,
  input  logic [FIFO_W-1:0] wdata_i,
  input  logic              pop_i,
  output logic [FIFO_W-1:0] rdata_o,
  output logic [CNT_W-1:0]  count_o
);

  logic [FIFO_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              do_push, do_pop;

  // Guarded push/pop so a misbehaving client can never corrupt the pointers.
  always_comb begin
    do_push  = push_i && (count_q != CNT_W'(FIFO_DEPTH));
    do_pop   = pop_i && (count_q != '0);
    wr_ptr_d = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d = rd_ptr_q + PTR_W'(do_pop);
    count_d  = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      for (int unsigned i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= wdata_i;
      end
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/ecc_rom_reader.sv
// Burst reader: streams len consecutive ROM words (with a last marker) through a
// credit-limited 4-deep FIFO to a valid/ready consumer.
module ecc_rom_reader
  import ecc_rom_reader_pkg::*;
(
  input  logic              CLK,
  input  logic              rst,
  input  logic              start,
  input  logic [ROM_AW-1:0] base_addr,
  input  logic [LEN_W-1:0]  len,
  output logic              busy,
  output logic              done,
  output logic              rom_cen,
  output logic [ROM_AW-1:0] rom_a,
  input  logic [ROM_DW-1:0] rom_q,
  output logic [ROM_DW-1:0] data,
  output logic              data_valid,
  input  logic              data_ready,
  output logic              data_last
);

  state_e            state_q, state_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              cen_q, cen_d;
  logic [ROM_AW-1:0] addr_q, addr_d;
  logic [LEN_W-1:0]  rem_q, rem_d;
  tag_t              tag1_q, tag1_d;
  tag_t              tag2_q, tag2_d;

  logic [FIFO_W-1:0] fifo_rdata;
  logic [CNT_W-1:0]  fifo_count;
  logic [CNT_W-1:0]  occ_c;
  logic              room_c;
  logic              xfer_c;

  ecc_rom_fifo u_fifo (
    .clk_i   (CLK),
    .rst_i   (rst),
    .push_i  (tag2_q.vld),
    .wdata_i ({tag2_q.last, rom_q}),
    .pop_i   (xfer_c),
    .rdata_o (fifo_rdata),
    .count_o (fifo_count)
  );

  assign data_valid = (fifo_count != '0);
  assign data       = fifo_rdata[ROM_DW-1:0];
  assign data_last  = data_valid && fifo_rdata[ROM_DW];
  assign xfer_c     = data_valid && data_ready;

  // Reads in flight count against FIFO space so a stalled consumer never overflows it.
  assign occ_c  = fifo_count + CNT_W'(tag1_q.vld) + CNT_W'(tag2_q.vld);
  assign room_c = (occ_c < CNT_W'(FIFO_DEPTH));

  always_comb begin
    state_d     = state_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cen_d       = 1'b1;
    addr_d      = addr_q;
    rem_d       = rem_q;
    tag1_d      = '0;
    tag2_d      = tag1_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (len == '0) begin
            done_d = 1'b1;
          end else begin
            busy_d      = 1'b1;
            cen_d       = 1'b0;
            addr_d      = base_addr;
            rem_d       = len - LEN_W'(1);
            tag1_d.vld  = 1'b1;
            tag1_d.last = (len == LEN_W'(1));
            state_d     = (len == LEN_W'(1)) ? ST_DRAIN : ST_FETCH;
          end
        end
      end
      ST_FETCH: begin
        if (room_c) begin
          cen_d       = 1'b0;
          addr_d      = addr_q + ROM_AW'(1);
          rem_d       = rem_q - LEN_W'(1);
          tag1_d.vld  = 1'b1;
          tag1_d.last = (rem_q == LEN_W'(1));
          if (rem_q == LEN_W'(1)) begin
            state_d = ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (xfer_c && data_last) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= ST_IDLE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      cen_q   <= 1'b1;
      addr_q  <= '0;
      rem_q   <= '0;
      tag1_q  <= '0;
      tag2_q  <= '0;
    end else begin
      state_q <= state_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      cen_q   <= cen_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      tag1_q  <= tag1_d;
      tag2_q  <= tag2_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rom_cen = cen_q;
  assign rom_a   = addr_q;

endmodule

// File: doc/ecc_rom_reader.md
ECC_ROM_READER -- requirements
Module: ecc_rom_reader

Interface
REQ-001 SHALL have port CLK, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1; reset is synchronous and active-high.
REQ-003 SHALL have port start, input, 1; burst request, sampled only while idle.
REQ-004 SHALL have port base_addr, input, 6; first ROM word address, latched on accepted start.
REQ-005 SHALL have port len, input, 5; word count 0..31, latched on accepted start.
REQ-006 SHALL have port busy, output, 1; high from the edge accepting start until the edge that raises done.
REQ-007 SHALL have port done, output, 1; one-cycle pulse at burst completion.
REQ-008 SHALL have port rom_cen, output, 1; registered, active-low ROM read enable.
REQ-009 SHALL have port rom_a, output, 6; registered ROM word address.
REQ-010 SHALL have port rom_q, input, 16; ROM data, valid one edge after the ROM samples rom_cen=0, held while rom_cen=1.
REQ-011 SHALL have port data, output, 16; FIFO head word.
REQ-012 SHALL have port data_valid, output, 1; data is valid.
REQ-013 SHALL have port data_ready, input, 1; consumer accepts; transfer occurs when data_valid and data_ready are both high at an edge.
REQ-014 SHALL have port data_last, output, 1; marks the final word of a burst.

Function
REQ-015 SHALL implement FSM IDLE -> FETCH on start with len>0 -> DRAIN after last read issued -> IDLE after last word transferred; IDLE with start and len=0 -> IDLE, done pulse on next edge, no ROM read.
REQ-016 SHALL ignore start while busy; latched base_addr and len are unaffected.
REQ-017 SHALL issue reads at base_addr, base_addr+1, ...; addresses modulo 64 (63 wraps to 0).
REQ-018 SHALL drive rom_cen=0 for exactly len cycles per burst, each with a distinct address; rom_cen=1 otherwise, and rom_a holds its value while rom_cen=1.
REQ-019 SHALL capture rom_q into the FIFO on the edge after the ROM sampling edge, using a two-stage in-flight tag pipeline and capturing only tagged cycles.
REQ-020 SHALL issue a read only when FIFO occupancy plus in-flight reads is less than 4, so the FIFO never overflows.
REQ-021 SHALL provide latency: start sampled at edge E0 -> rom_cen=0 after E0 -> data_valid=1 after E2.
REQ-022 SHALL sustain one word per cycle when data_ready is held high.
REQ-023 SHALL never present data_valid=1 with an empty FIFO; data and data_last hold stable while data_valid=1 and data_ready=0.
REQ-024 SHALL set data_last=1 only with the len-th word of a burst.
REQ-025 SHALL assert done on the edge following the data_last transfer; busy falls on that same edge.
REQ-026 SHALL accept a new start in the cycle done is high; that start is sampled as if idle.

Reset
REQ-027 SHALL, on rst=1 at an edge, set: state IDLE; busy=0; done=0; rom_cen=1; rom_a=0; data_valid=0; data=0; data_last=0; FIFO and in-flight tags cleared.
REQ-028 SHALL give rst priority over all other inputs; rst mid-burst aborts without a done pulse, and data from reads already issued is discarded.

Structure
REQ-029 SHALL take ROM_AW=6, ROM_DW=16, FIFO_DEPTH=4, LEN_W=5 and the FSM state encoding from the shared ECC package.
REQ-030 SHALL instantiate one sub-module, ecc_rom_fifo: synchronous 4x17 FIFO (data plus last bit) with push, pop, count, and synchronous active-high reset.

Verification
REQ-031 SHALL verify: base=0, len=3, data_ready=1 -> data 0xDCDC, 0x34B2, 0x8FAA on consecutive cycles; data_last with the 3rd word; done one cycle later.
REQ-032 SHALL verify: base=62, len=3 -> rom_a sequence 62, 63, 0; 1st word 0xB663; 3rd word 0xDCDC.
REQ-033 SHALL verify: base=16, len=5, data_ready=0 for 10 cycles after the first data_valid -> no more than 4 reads outstanding, stalls hold data stable, output 0x78F6, 0x1800, 0x1111, 0x2222, 0x3333.
REQ-034 SHALL verify: len=0 -> done pulse one cycle after start, rom_cen stays 1, data_valid stays 0.
REQ-035 SHALL verify: start during busy is ignored; rst asserted mid-burst gives reset values after the next edge, no done pulse; a following start with base=0, len=1 returns 0xDCDC.
